spi_reg_decoder: RTL and testbench
==================================

Name: spi_reg_decoder

Overview:
- Consumes 16-bit words from the SPI slave receive stage and turns them into register-bank transactions.
- First word of each SSEL frame is a command word; the following words are write data or read dummies.
- Drives a write port into the 64x16 command register bank and a read port from the 64x16 data register bank.
- Returns read data to the SPI slave as the next word to shift out on MISO.

Parameters:
ADDR_W, 6, register address width (bank depth 2^ADDR_W)
DATA_W, 16, word width; must equal the SPI word width

Ports:
SYS_CLK  in  1  system clock; all logic on rising edge
RST_N  in  1  asynchronous active-low reset
FRAME_ACTIVE  in  1  SSEL active (already synchronised by SPI stage), high for the duration of a frame
RX_VALID  in  1  single-cycle strobe: RX_WORD holds a newly received word
RX_WORD  in  16  received word, MSb first as shifted
TX_WORD  out  16  word the SPI stage shifts out on the next word slot
WR_EN  out  1  single-cycle write strobe to command register bank
WR_ADDR  out  6  write address
WR_DATA  out  16  write data
RD_ADDR  out  6  read address to data register bank
RD_DATA  in  16  read data; valid exactly 1 cycle after RD_ADDR changes
ERR_CNT  out  8  saturating protocol-error counter

Behaviour:
- Reset (RST_N low, async): state IDLE; TX_WORD=16'h0000; WR_EN=0; WR_ADDR=0; WR_DATA=0; RD_ADDR=0; ERR_CNT=0; address pointer=0; burst flag=0.
- Command word format: [15] WR (1=write, 0=read); [14] BURST (1=auto-increment address); [13:6] reserved, must be 0; [5:0] ADDR.
- States: IDLE, WR_DATA, RD_DATA.
- IDLE, RX_VALID with FRAME_ACTIVE high:
  - Reserved bits nonzero: ERR_CNT+1; stay IDLE; TX_WORD=16'hDEAD.
  - WR=1: pointer=ADDR; go to WR_DATA; TX_WORD=RX_WORD (echo).
  - WR=0: pointer=ADDR; RD_ADDR=ADDR same cycle as the state change; go to RD_DATA. The cycle after, TX_WORD<=RD_DATA. TX_WORD is therefore stable 2 cycles after RX_VALID.
- WR_DATA, each RX_VALID:
  - WR_EN=1 for exactly one cycle, with WR_ADDR=pointer and WR_DATA=RX_WORD, both registered (1-cycle latency after RX_VALID).
  - TX_WORD=RX_WORD (echo).
  - BURST=1: pointer+1, wrapping 63 to 0. BURST=0: pointer holds, so repeated words rewrite the same register.
- RD_DATA, each RX_VALID (word content ignored):
  - BURST=1: pointer+1 with wrap; RD_ADDR=new pointer; TX_WORD<=RD_DATA one cycle later.
  - BURST=0: re-read the same address; TX_WORD refreshed with the current RD_DATA.
- FRAME_ACTIVE low in any state: return to IDLE on the next edge; burst flag cleared; TX_WORD holds its value (needed for the next frame's preload).
- RX_VALID and FRAME_ACTIVE low in the same cycle: word dropped, ERR_CNT+1, no write.
- Frame ending mid-word: no RX_VALID arrives, so no write occurs; not an error.
- ERR_CNT saturates at 255; no wrap.
- RX_VALID pulses are at least 16 SPI bit-times apart, so no back-to-back handling is required. If RX_VALID arrives while a read capture is pending, the capture completes first, then the new word is processed.
- Reset asserted mid-transaction: all state clears immediately; no partial WR_EN pulse.

Test Plan:
- Single write: frame {16'h8005, 16'h0123} -> exactly one WR_EN pulse with WR_ADDR=5, WR_DATA=16'h0123; TX_WORD=16'h0123 afterward; state IDLE after FRAME_ACTIVE drops.
- Burst write with wrap: {16'hC03E, 16'hAAAA, 16'hBBBB, 16'hCCCC} -> writes to addr 62, 63, 0 with those values; 3 WR_EN pulses total.
- Read: RD_DATA model returns 16'h1000+addr; frame {16'h0007, dummy} -> RD_ADDR=7; TX_WORD=16'h1007 two cycles after the first RX_VALID; no WR_EN.
- Burst read: {16'h4010, d, d} -> TX_WORD sequence 16'h1010, 16'h1011, 16'h1012.
- Errors: command 16'h8105 -> ERR_CNT=1, TX_WORD=16'hDEAD, no write. RX_VALID with FRAME_ACTIVE low -> ERR_CNT=2. 300 bad commands -> ERR_CNT=255.
- Async reset mid-burst-write, after the 2nd data word -> all outputs return to reset values without waiting for a SYS_CLK edge. A following frame {16'h8001, 16'h5555} writes addr 1 only.

Source files
------------

// File: rtl/spi_reg_decoder.sv
// ---------------------------------------------------------------------------
// spi_reg_decoder
//   Turns 16-bit words from the SPI slave receive stage into register-bank
//   transactions. The first word of each frame is a command:
//     [15] WR, [14] BURST, [13:6] reserved (must be 0), [5:0] ADDR.
//   Later words in the frame are either write data, which goes to the command
//   bank, or read dummies, which fetch from the data bank.
//
// Ports
//   i_sys_clk       system clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_frame_active  SSEL active (already synchronised)
//   i_rx_valid      one-cycle strobe: i_rx_word holds a new word
//   i_rx_word       received word
//   o_tx_word       word to shift out in the next word slot
//   o_wr_en         one-cycle write strobe to the command register bank
//   o_wr_addr       write address
//   o_wr_data       write data
//   o_rd_addr       read address to the data register bank
//   i_rd_data       read data, valid one cycle after o_rd_addr changes
//   o_err_cnt       saturating protocol-error counter
// ---------------------------------------------------------------------------
module spi_reg_decoder #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              i_sys_clk,
    input  logic              i_rst_n,
    input  logic              i_frame_active,
    input  logic              i_rx_valid,
    input  logic [DATA_W-1:0] i_rx_word,
    output logic [DATA_W-1:0] o_tx_word,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [7:0]        o_err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR_DATA = 2'd1,
        S_RD_DATA = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_tx_word;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [7:0]        r_err_cnt;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_burst;
    logic              r_rd_pending;   // o_rd_addr moved last cycle; capture i_rd_data now
    logic              r_rx_deferred;  // word arrived during a capture, process it now
    logic [DATA_W-1:0] r_rx_buf;

    logic              w_rx_go;
    logic [DATA_W-1:0] w_rx_data;
    logic              w_rsvd_bad;
    logic              w_cmd_wr;
    logic              w_cmd_burst;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic [ADDR_W-1:0] w_ptr_next;
    logic [7:0]        w_err_next;

    // A word landing on the capture cycle is parked for one cycle, so the
    // pending read always reaches o_tx_word before the new word is acted on.
    assign w_rx_go     = (i_rx_valid && !r_rd_pending) || r_rx_deferred;
    assign w_rx_data   = r_rx_deferred ? r_rx_buf : i_rx_word;
    assign w_rsvd_bad  = |w_rx_data[DATA_W-3:ADDR_W];
    assign w_cmd_wr    = w_rx_data[DATA_W-1];
    assign w_cmd_burst = w_rx_data[DATA_W-2];
    assign w_cmd_addr  = w_rx_data[ADDR_W-1:0];
    assign w_ptr_next  = r_ptr + ADDR_W'(1);    // wraps naturally at 2^ADDR_W
    assign w_err_next  = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;

    // NOTE: every register here is updated with non-blocking assignments so
    // all reads in this block see pre-edge values regardless of statement order.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_tx_word     <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_rd_addr     <= '0;
            r_err_cnt     <= '0;
            r_ptr         <= '0;
            r_burst       <= 1'b0;
            r_rd_pending  <= 1'b0;
            r_rx_deferred <= 1'b0;
            r_rx_buf      <= '0;
        end else begin
            r_wr_en       <= 1'b0;
            r_rx_deferred <= 1'b0;

            if (r_rd_pending) begin
                r_tx_word    <= i_rd_data;
                r_rd_pending <= 1'b0;
                if (i_rx_valid) begin
                    r_rx_deferred <= 1'b1;
                    r_rx_buf      <= i_rx_word;
                end
            end

            if (!i_frame_active) begin
                // o_tx_word is left alone: it preloads the next frame's first slot.
                r_state <= S_IDLE;
                r_burst <= 1'b0;
                if (w_rx_go) begin
                    r_err_cnt <= w_err_next;
                end
            end else if (w_rx_go) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_rsvd_bad) begin
                            r_err_cnt <= w_err_next;
                            r_tx_word <= 16'hDEAD;
                        end else if (w_cmd_wr) begin
                            r_ptr     <= w_cmd_addr;
                            r_burst   <= w_cmd_burst;
                            r_tx_word <= w_rx_data;
                            r_state   <= S_WR_DATA;
                        end else begin
                            r_ptr        <= w_cmd_addr;
                            r_burst      <= w_cmd_burst;
                            r_rd_addr    <= w_cmd_addr;
                            r_rd_pending <= 1'b1;
                            r_state      <= S_RD_DATA;
                        end
                    end
                    S_WR_DATA: begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_ptr;
                        r_wr_data <= w_rx_data;
                        r_tx_word <= w_rx_data;
                        if (r_burst) begin
                            r_ptr <= w_ptr_next;
                        end
                    end
                    S_RD_DATA: begin
                        if (r_burst) begin
                            r_ptr        <= w_ptr_next;
                            r_rd_addr    <= w_ptr_next;
                            r_rd_pending <= 1'b1;
                        end else begin
                            // Address unchanged, so i_rd_data is already valid.
                            r_tx_word <= i_rd_data;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_tx_word = r_tx_word;
    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_rd_addr = r_rd_addr;
    assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_spi_reg_decoder.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_decoder
//   Self-checking bench for spi_reg_decoder. The data bank is modelled as
//   rd_data = 16'h1000 + rd_addr. A frame-level reference model predicts the
//   writes, the final TX word and the error count.
// ---------------------------------------------------------------------------
module tb_spi_reg_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_active = 1'b0;
    logic        rx_valid = 1'b0;
    logic [15:0] rx_word = 16'h0000;
    logic [15:0] tx_word;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic [5:0]  rd_addr;
    logic [15:0] rd_data;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;

    logic [21:0] got_wr[$];
    logic [21:0] exp_wr[$];
    logic [15:0] fw[$];
    logic [15:0] exp_tx;
    int          exp_err;

    spi_reg_decoder #(.ADDR_W(6), .DATA_W(16)) dut (
        .i_sys_clk      (clk),
        .i_rst_n        (rst_n),
        .i_frame_active (frame_active),
        .i_rx_valid     (rx_valid),
        .i_rx_word      (rx_word),
        .o_tx_word      (tx_word),
        .o_wr_en        (wr_en),
        .o_wr_addr      (wr_addr),
        .o_wr_data      (wr_data),
        .o_rd_addr      (rd_addr),
        .i_rd_data      (rd_data),
        .o_err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    assign rd_data = 16'h1000 + {10'd0, rd_addr};

    always @(negedge clk) begin
        if (rst_n && wr_en) got_wr.push_back({wr_addr, wr_data});
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send_word(input logic [15:0] w);
        @(negedge clk);
        rx_word  = w;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic run_frame();
        @(negedge clk);
        frame_active = 1'b1;
        repeat (2) @(negedge clk);
        foreach (fw[i]) send_word(fw[i]);
        frame_active = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Frame-level reference: walks the words of fw applying the protocol rules.
    task automatic model_frame();
        bit have_cmd = 1'b0;
        bit is_wr    = 1'b0;
        bit is_burst = 1'b0;
        int ptr      = 0;
        exp_wr.delete();
        foreach (fw[i]) begin
            int v = int'(fw[i]);
            if (!have_cmd) begin
                if (((v / 64) % 256) != 0) begin
                    if (exp_err < 255) exp_err = exp_err + 1;
                    exp_tx = 16'hDEAD;
                end else begin
                    have_cmd = 1'b1;
                    is_wr    = (v >= 32768);
                    is_burst = ((v / 16384) % 2) == 1;
                    ptr      = v % 64;
                    exp_tx   = is_wr ? fw[i] : 16'(4096 + ptr);
                end
            end else if (is_wr) begin
                exp_wr.push_back({6'(ptr), fw[i]});
                exp_tx = fw[i];
                if (is_burst) ptr = (ptr + 1) % 64;
            end else begin
                if (is_burst) ptr = (ptr + 1) % 64;
                exp_tx = 16'(4096 + ptr);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total += 6;
        if (tx_word !== 16'h0000) begin bad++; $display("FAIL reset_tx got=%h exp=0000", tx_word); end
        if (wr_en !== 1'b0)       begin bad++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        if (wr_addr !== 6'd0)     begin bad++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
        if (wr_data !== 16'h0000) begin bad++; $display("FAIL reset_wr_data got=%h exp=0000", wr_data); end
        if (rd_addr !== 6'd0)     begin bad++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); end
        if (err_cnt !== 8'd0)     begin bad++; $display("FAIL reset_err got=%0d exp=0", err_cnt); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_write();
        got_wr.delete();
        fw = '{16'h8005, 16'h0123};
        run_frame();
        total += 2;
        if (got_wr.size() != 1) begin
            bad++; $display("FAIL single_wr_count got=%0d exp=1", got_wr.size());
        end else if (got_wr[0] !== {6'd5, 16'h0123}) begin
            bad++; $display("FAIL single_wr_entry got=%h exp=%h", got_wr[0], {6'd5, 16'h0123});
        end
        if (tx_word !== 16'h0123) begin bad++; $display("FAIL single_wr_tx got=%h exp=0123", tx_word); end
    endtask

    task automatic test_burst_write();
        logic [21:0] want[3];
        want[0] = {6'd62, 16'hAAAA};
        want[1] = {6'd63, 16'hBBBB};
        want[2] = {6'd0,  16'hCCCC};
        got_wr.delete();
        fw = '{16'hC03E, 16'hAAAA, 16'hBBBB, 16'hCCCC};
        run_frame();
        total++;
        if (got_wr.size() != 3) begin
            bad++; $display("FAIL burst_wr_count got=%0d exp=3", got_wr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (got_wr[i] !== want[i]) begin
                    bad++; $display("FAIL burst_wr_entry%0d got=%h exp=%h", i, got_wr[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_read();
        got_wr.delete();
        @(negedge clk);
        frame_active = 1'b1;
        repeat (2) @(negedge clk);
        rx_word  = 16'h0007;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        total++;
        if (rd_addr !== 6'd7) begin bad++; $display("FAIL read_rd_addr got=%0d exp=7", rd_addr); end
        @(negedge clk);
        total++;
        if (tx_word !== 16'h1007) begin bad++; $display("FAIL read_tx_2cyc got=%h exp=1007", tx_word); end
        repeat (4) @(negedge clk);
        send_word(16'h5A5A);
        frame_active = 1'b0;
        repeat (3) @(negedge clk);
        total += 2;
        if (tx_word !== 16'h1007) begin bad++; $display("FAIL read_tx_reread got=%h exp=1007", tx_word); end
        if (got_wr.size() != 0)   begin bad++; $display("FAIL read_no_write got=%0d exp=0", got_wr.size()); end
    endtask

    task automatic test_burst_read();
        logic [15:0] want[3];
        logic [15:0] words[3];
        want  = '{16'h1010, 16'h1011, 16'h1012};
        words = '{16'h4010, 16'hFFFF, 16'h0000};
        got_wr.delete();
        @(negedge clk);
        frame_active = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            send_word(words[i]);
            total++;
            if (tx_word !== want[i]) begin
                bad++; $display("FAIL burst_rd_tx%0d got=%h exp=%h", i, tx_word, want[i]);
            end
        end
        frame_active = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (got_wr.size() != 0) begin bad++; $display("FAIL burst_rd_no_write got=%0d exp=0", got_wr.size()); end
    endtask

    task automatic test_errors();
        got_wr.delete();
        fw = '{16'h8105};
        run_frame();
        total += 3;
        if (err_cnt !== 8'd1)     begin bad++; $display("FAIL err_rsvd_cnt got=%0d exp=1", err_cnt); end
        if (tx_word !== 16'hDEAD) begin bad++; $display("FAIL err_rsvd_tx got=%h exp=DEAD", tx_word); end
        if (got_wr.size() != 0)   begin bad++; $display("FAIL err_rsvd_no_write got=%0d exp=0", got_wr.size()); end

        send_word(16'h8001);  // frame inactive
        total += 2;
        if (err_cnt !== 8'd2)   begin bad++; $display("FAIL err_noframe_cnt got=%0d exp=2", err_cnt); end
        if (got_wr.size() != 0) begin bad++; $display("FAIL err_noframe_no_write got=%0d exp=0", got_wr.size()); end

        @(negedge clk);
        frame_active = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            send_word(16'h0040 | 16'($urandom_range(0, 16'hFFFF) & 16'hBFFF));
            if (i == 252) begin
                total++;
                if (err_cnt !== 8'd255) begin bad++; $display("FAIL err_reach_255 got=%0d exp=255", err_cnt); end
            end
        end
        frame_active = 1'b0;
        repeat (3) @(negedge clk);
        total += 2;
        if (err_cnt !== 8'd255) begin bad++; $display("FAIL err_saturate got=%0d exp=255", err_cnt); end
        if (got_wr.size() != 0) begin bad++; $display("FAIL err_sat_no_write got=%0d exp=0", got_wr.size()); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        frame_active = 1'b1;
        repeat (2) @(negedge clk);
        send_word(16'hC03E);
        send_word(16'hAAAA);
        send_word(16'hBBBB);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;  // still before the next rising edge
        total += 6;
        if (tx_word !== 16'h0000) begin bad++; $display("FAIL arst_tx got=%h exp=0000", tx_word); end
        if (wr_en !== 1'b0)       begin bad++; $display("FAIL arst_wr_en got=%b exp=0", wr_en); end
        if (wr_addr !== 6'd0)     begin bad++; $display("FAIL arst_wr_addr got=%0d exp=0", wr_addr); end
        if (wr_data !== 16'h0000) begin bad++; $display("FAIL arst_wr_data got=%h exp=0000", wr_data); end
        if (rd_addr !== 6'd0)     begin bad++; $display("FAIL arst_rd_addr got=%0d exp=0", rd_addr); end
        if (err_cnt !== 8'd0)     begin bad++; $display("FAIL arst_err got=%0d exp=0", err_cnt); end
        frame_active = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        got_wr.delete();
        fw = '{16'h8001, 16'h5555};
        run_frame();
        total++;
        if (got_wr.size() != 1) begin
            bad++; $display("FAIL arst_after_count got=%0d exp=1", got_wr.size());
        end else begin
            total++;
            if (got_wr[0] !== {6'd1, 16'h5555}) begin
                bad++; $display("FAIL arst_after_entry got=%h exp=%h", got_wr[0], {6'd1, 16'h5555});
            end
        end
    endtask

    task automatic test_random();
        exp_err = int'(err_cnt === 8'd0 ? 0 : 0);
        for (int f = 0; f < 40; f++) begin
            int          len;
            logic [15:0] cmd;
            logic [7:0]  rsv;
            rsv = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            cmd = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rsv, 6'($urandom_range(0, 63))};
            len = $urandom_range(1, 5);
            fw.delete();
            fw.push_back(cmd);
            for (int k = 1; k < len; k++) fw.push_back(16'($urandom_range(0, 16'hFFFF)));
            model_frame();
            got_wr.delete();
            run_frame();
            total += 3;
            if (tx_word !== exp_tx) begin
                bad++; $display("FAIL rand%0d_tx got=%h exp=%h", f, tx_word, exp_tx);
            end
            if (err_cnt !== 8'(exp_err)) begin
                bad++; $display("FAIL rand%0d_err got=%0d exp=%0d", f, err_cnt, exp_err);
            end
            if (got_wr.size() != exp_wr.size()) begin
                bad++; $display("FAIL rand%0d_wr_count got=%0d exp=%0d", f, got_wr.size(), exp_wr.size());
            end else begin
                foreach (exp_wr[i]) begin
                    total++;
                    if (got_wr[i] !== exp_wr[i]) begin
                        bad++; $display("FAIL rand%0d_wr%0d got=%h exp=%h", f, i, got_wr[i], exp_wr[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_write();
        test_read();
        test_burst_read();
        test_errors();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
